// File: rtl/i2cmb_seq_pkg.sv
// rtl/i2cmb_seq_pkg.sv - shared constants and types for the i2cmb Wishbone sequencer
package i2cmb_seq_pkg;

    // Controller register map
    localparam logic [1:0] CSR_ADDR  = 2'd0;
    localparam logic [1:0] DPR_ADDR  = 2'd1;
    localparam logic [1:0] CMDR_ADDR = 2'd2;

    // CMDR command codes
    localparam logic [7:0] CMD_WAIT      = 8'h00;
    localparam logic [7:0] CMD_WRITE     = 8'h01;
    localparam logic [7:0] CMD_READ_ACK  = 8'h02;
    localparam logic [7:0] CMD_READ_NACK = 8'h03;
    localparam logic [7:0] CMD_START     = 8'h04;
    localparam logic [7:0] CMD_STOP      = 8'h05;
    localparam logic [7:0] CMD_SET_BUS   = 8'h06;

    // CSR value written once after reset: core enable + interrupt enable
    localparam logic [7:0] CSR_ENABLE = 8'hC0;

    // CMDR status bit positions
    localparam int CMDR_DON = 7;
    localparam int CMDR_NAK = 6;
    localparam int CMDR_AL  = 5;
    localparam int CMDR_ERR = 4;

    typedef enum logic [1:0] {
        STAT_OK       = 2'b00,
        STAT_ADDR_NAK = 2'b01,
        STAT_DATA_NAK = 2'b10,
        STAT_ARB_ERR  = 2'b11
    } seq_status_e;

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_BUS_DPR,
        S_CMD,
        S_WAIT_IRQ,
        S_READ_CMDR,
        S_EVAL,
        S_ADDR_DPR,
        S_WR_WAIT,
        S_WR_DPR,
        S_RD_DPR,
        S_RD_PUSH
    } seq_state_e;

endpackage

// File: rtl/i2cmb_wb_access.sv
// rtl/i2cmb_wb_access.sv - single-access Wishbone master engine
//
// Ports:
//   clk_i, rst_ni         clock, synchronous active-low reset
//   start                 launch one access (ignored while an access is in flight)
//   we, adr, wdata        access attributes, latched on start
//   done                  high in the cycle ack_i is sampled
//   rdata                 read data captured on the ack of a read
//   cyc_o..dat_o          Wishbone master outputs, held stable until ack
//   dat_i, ack_i          Wishbone slave returns
module i2cmb_wb_access #(
    parameter int AW = 2,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start,
    input  logic          we,
    input  logic [AW-1:0] adr,
    input  logic [DW-1:0] wdata,
    output logic          done,
    output logic [DW-1:0] rdata,
    output logic          cyc_o,
    output logic          stb_o,
    output logic          we_o,
    output logic [AW-1:0] adr_o,
    output logic [DW-1:0] dat_o,
    input  logic [DW-1:0] dat_i,
    input  logic          ack_i
);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cyc_o <= 1'b0;
            stb_o <= 1'b0;
            we_o  <= 1'b0;
            adr_o <= '0;
            dat_o <= '0;
            rdata <= '0;
        end else if (cyc_o) begin
            if (ack_i) begin
                cyc_o <= 1'b0;
                stb_o <= 1'b0;
                we_o  <= 1'b0;
                adr_o <= '0;
                dat_o <= '0;
                if (!we_o) begin
                    rdata <= dat_i;
                end
            end
        end else if (start) begin
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            we_o  <= we;
            adr_o <= adr;
            dat_o <= wdata;
        end
    end

    // The caller leaves its access state on this cycle, so the bus is
    // guaranteed at least one idle cycle before the next start.
    assign done = cyc_o & ack_i;

endmodule

// File: rtl/i2cmb_wb_sequencer.sv
// rtl/i2cmb_wb_sequencer.sv - expands I2C transfer requests into i2cmb Wishbone register sequences
//
// Ports:
//   clk_i, rst_ni                       clock, synchronous active-low reset
//   req_valid_i/req_ready_o, req_*      transfer request (bus, address, direction, length-1)
//   wdata_valid_i/wdata_ready_o, wdata_i  write byte stream
//   rdata_valid_o, rdata_o              received byte pulse (no backpressure)
//   resp_valid_o, resp_status_o         end-of-transfer pulse and status
//   cyc_o, stb_o, we_o, adr_o, dat_o, dat_i, ack_i  Wishbone master to the controller
//   irq_i                               controller command-complete interrupt
module i2cmb_wb_sequencer
    import i2cmb_seq_pkg::*;
#(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int I2C_ADDR_WIDTH = 7,
    parameter int NUM_I2C_BUSSES = 1,
    parameter int BUS_W = (NUM_I2C_BUSSES > 1) ? $clog2(NUM_I2C_BUSSES) : 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [BUS_W-1:0]          req_bus_i,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
    input  logic                      req_rd_i,
    input  logic [3:0]                req_len_i,
    input  logic                      wdata_valid_i,
    output logic                      wdata_ready_o,
    input  logic [WB_DATA_WIDTH-1:0]  wdata_i,
    output logic                      rdata_valid_o,
    output logic [WB_DATA_WIDTH-1:0]  rdata_o,
    output logic                      resp_valid_o,
    output logic [1:0]                resp_status_o,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [WB_ADDR_WIDTH-1:0]  adr_o,
    output logic [WB_DATA_WIDTH-1:0]  dat_o,
    input  logic [WB_DATA_WIDTH-1:0]  dat_i,
    input  logic                      ack_i,
    input  logic                      irq_i
);

    seq_state_e                 state_q, state_d;
    seq_status_e                status_q, status_d, fin_status;
    logic [BUS_W-1:0]           bus_q;
    logic [I2C_ADDR_WIDTH-1:0]  addr_q;
    logic                       rd_q;
    logic [3:0]                 len_q;
    logic [3:0]                 cnt_q, cnt_d;
    logic [7:0]                 cmd_q, cmd_d;
    logic [WB_DATA_WIDTH-1:0]   wbyte_q, wbyte_d;
    logic                       addr_phase_q, addr_phase_d;

    logic                       acc_req, acc_start, acc_we, acc_done;
    logic [WB_ADDR_WIDTH-1:0]   acc_adr;
    logic [WB_DATA_WIDTH-1:0]   acc_wdata, acc_rdata;
    logic                       req_ready, accept, finish, fail_arb;

    i2cmb_wb_access #(
        .AW (WB_ADDR_WIDTH),
        .DW (WB_DATA_WIDTH)
    ) u_access (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .start  (acc_start),
        .we     (acc_we),
        .adr    (acc_adr),
        .wdata  (acc_wdata),
        .done   (acc_done),
        .rdata  (acc_rdata),
        .cyc_o  (cyc_o),
        .stb_o  (stb_o),
        .we_o   (we_o),
        .adr_o  (adr_o),
        .dat_o  (dat_o),
        .dat_i  (dat_i),
        .ack_i  (ack_i)
    );

    // Access states hold acc_req for their whole duration; a new access is
    // only launched while the engine is idle.
    assign acc_start = acc_req & ~cyc_o;

    // acc_rdata holds the last CMDR read while in S_EVAL.
    assign fail_arb   = acc_rdata[CMDR_AL] | acc_rdata[CMDR_ERR];
    assign fin_status = (fail_arb && status_q == STAT_OK) ? STAT_ARB_ERR : status_q;
    assign accept     = req_ready & req_valid_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_INIT;
            status_q     <= STAT_OK;
            bus_q        <= '0;
            addr_q       <= '0;
            rd_q         <= 1'b0;
            len_q        <= 4'd0;
            cnt_q        <= 4'd0;
            cmd_q        <= CMD_WAIT;
            wbyte_q      <= '0;
            addr_phase_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            cnt_q        <= cnt_d;
            cmd_q        <= cmd_d;
            wbyte_q      <= wbyte_d;
            addr_phase_q <= addr_phase_d;
            if (accept) begin
                bus_q  <= req_bus_i;
                addr_q <= req_addr_i;
                rd_q   <= req_rd_i;
                len_q  <= req_len_i;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        status_d      = status_q;
        cnt_d         = cnt_q;
        cmd_d         = cmd_q;
        wbyte_d       = wbyte_q;
        addr_phase_d  = addr_phase_q;
        acc_req       = 1'b0;
        acc_we        = 1'b0;
        acc_adr       = '0;
        acc_wdata     = '0;
        req_ready     = 1'b0;
        wdata_ready_o = 1'b0;
        rdata_valid_o = 1'b0;
        finish        = 1'b0;

        case (state_q)
            S_INIT: begin
                acc_req   = 1'b1;
                acc_we    = 1'b1;
                acc_adr   = WB_ADDR_WIDTH'(CSR_ADDR);
                acc_wdata = WB_DATA_WIDTH'(CSR_ENABLE);
                if (acc_done) state_d = S_IDLE;
            end
            S_IDLE: begin
                req_ready = 1'b1;
            end
            S_BUS_DPR: begin
                acc_req   = 1'b1;
                acc_we    = 1'b1;
                acc_adr   = WB_ADDR_WIDTH'(DPR_ADDR);
                acc_wdata = WB_DATA_WIDTH'(bus_q);
                if (acc_done) begin
                    cmd_d   = CMD_SET_BUS;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                acc_req   = 1'b1;
                acc_we    = 1'b1;
                acc_adr   = WB_ADDR_WIDTH'(CMDR_ADDR);
                acc_wdata = WB_DATA_WIDTH'(cmd_q);
                if (acc_done) state_d = S_WAIT_IRQ;
            end
            S_WAIT_IRQ: begin
                // A level already high here counts as completion.
                if (irq_i) state_d = S_READ_CMDR;
            end
            S_READ_CMDR: begin
                acc_req = 1'b1;
                acc_adr = WB_ADDR_WIDTH'(CMDR_ADDR);
                if (acc_done) state_d = S_EVAL;
            end
            S_EVAL: begin
                if (fail_arb) begin
                    // Arbitration lost / bus error: the bus is not ours, skip STOP.
                    status_d = fin_status;
                    finish   = 1'b1;
                end else if (cmd_q == CMD_WRITE && acc_rdata[CMDR_NAK]) begin
                    if (status_q == STAT_OK) begin
                        status_d = addr_phase_q ? STAT_ADDR_NAK : STAT_DATA_NAK;
                    end
                    addr_phase_d = 1'b0;
                    cmd_d        = CMD_STOP;
                    state_d      = S_CMD;
                end else begin
                    case (cmd_q)
                        CMD_SET_BUS: begin
                            cmd_d   = CMD_START;
                            state_d = S_CMD;
                        end
                        CMD_START: state_d = S_ADDR_DPR;
                        CMD_WRITE: begin
                            if (addr_phase_q) begin
                                addr_phase_d = 1'b0;
                                if (rd_q) begin
                                    cmd_d   = (len_q == 4'd0) ? CMD_READ_NACK : CMD_READ_ACK;
                                    state_d = S_CMD;
                                end else begin
                                    state_d = S_WR_WAIT;
                                end
                            end else if (cnt_q == len_q) begin
                                cmd_d   = CMD_STOP;
                                state_d = S_CMD;
                            end else begin
                                cnt_d   = cnt_q + 4'd1;
                                state_d = S_WR_WAIT;
                            end
                        end
                        CMD_READ_ACK,
                        CMD_READ_NACK: state_d = S_RD_DPR;
                        default: finish = 1'b1;
                    endcase
                end
                if (finish) begin
                    req_ready = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_ADDR_DPR: begin
                acc_req   = 1'b1;
                acc_we    = 1'b1;
                acc_adr   = WB_ADDR_WIDTH'(DPR_ADDR);
                acc_wdata = WB_DATA_WIDTH'({addr_q, rd_q});
                if (acc_done) begin
                    addr_phase_d = 1'b1;
                    cmd_d        = CMD_WRITE;
                    state_d      = S_CMD;
                end
            end
            S_WR_WAIT: begin
                // Wishbone stays idle for as long as the write stream stalls.
                wdata_ready_o = 1'b1;
                if (wdata_valid_i) begin
                    wbyte_d = wdata_i;
                    state_d = S_WR_DPR;
                end
            end
            S_WR_DPR: begin
                acc_req   = 1'b1;
                acc_we    = 1'b1;
                acc_adr   = WB_ADDR_WIDTH'(DPR_ADDR);
                acc_wdata = wbyte_q;
                if (acc_done) begin
                    cmd_d   = CMD_WRITE;
                    state_d = S_CMD;
                end
            end
            S_RD_DPR: begin
                acc_req = 1'b1;
                acc_adr = WB_ADDR_WIDTH'(DPR_ADDR);
                if (acc_done) state_d = S_RD_PUSH;
            end
            S_RD_PUSH: begin
                rdata_valid_o = 1'b1;
                if (cnt_q == len_q) begin
                    cmd_d = CMD_STOP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    cmd_d = ((cnt_q + 4'd1) == len_q) ? CMD_READ_NACK : CMD_READ_ACK;
                end
                state_d = S_CMD;
            end
            default: state_d = S_INIT;
        endcase

        // A request taken in the response cycle starts straight away.
        if (accept) begin
            state_d      = S_BUS_DPR;
            status_d     = STAT_OK;
            cnt_d        = 4'd0;
            addr_phase_d = 1'b0;
        end
    end

    assign req_ready_o   = req_ready;
    assign resp_valid_o  = finish;
    assign resp_status_o = finish ? fin_status : STAT_OK;
    assign rdata_o       = (state_q == S_RD_PUSH) ? acc_rdata : '0;

endmodule
